// File: rtl/uart_alu_ctrl_if.sv
// Signal bundle between the frame sequencer and its RX/TX FIFOs, ALU and status consumers.
// master is the sequencer side; slave is the FIFO/ALU/environment side.
interface uart_alu_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
);
  logic [DATA_W-1:0] r_data;
  logic              rx_empty;
  logic              rd;
  logic [DATA_W-1:0] w_data;
  logic              tx_full;
  logic              wr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              busy;
  logic              frame_done;
  logic              timeout;

  modport master (
    input  r_data, rx_empty, tx_full, alu_result,
    output rd, w_data, wr, alu_a, alu_b, alu_op, busy, frame_done, timeout
  );

  modport slave (
    output r_data, rx_empty, tx_full, alu_result,
    input  rd, w_data, wr, alu_a, alu_b, alu_op, busy, frame_done, timeout
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops operand A, operand B and opcode from the RX FIFO, runs the ALU
// for one cycle and pushes the result byte into the TX FIFO. Stalled partial frames time out.
module uart_alu_ctrl #(
  parameter int DATA_W         = 8,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_alu_ctrl_if.master  bus
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [DATA_W-1:0] aluA_q;
  logic [DATA_W-1:0] aluB_q;
  logic [OP_W-1:0]   aluOp_q;
  logic [DATA_W-1:0] wData_q;
  logic [TO_W-1:0]   toCnt_q;
  logic              frameDone_q;
  logic              timeout_q;

  logic              popEn;
  logic              pushEn;
  logic              toExpire;
  logic [TO_W-1:0]   toCnt_d;

  // A pop always beats an expiring counter; a zero timeout keeps the counter parked at 0.
  always_comb begin
    popEn    = !reset && (state_q inside {GET_A, GET_B, GET_OP}) && !bus.rx_empty;
    pushEn   = !reset && (state_q == SEND) && !bus.tx_full;
    toExpire = (TIMEOUT_CYCLES != 0) && (toCnt_q == ToLast) && !popEn;
    toCnt_d  = (popEn || TIMEOUT_CYCLES == 0) ? '0 : toCnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GET_A;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      wData_q     <= '0;
      toCnt_q     <= '0;
      frameDone_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        GET_A: begin
          toCnt_q <= '0;
          if (popEn) begin
            aluA_q  <= bus.r_data;
            state_q <= GET_B;
          end
        end
        GET_B, GET_OP: begin
          if (toExpire) begin
            state_q   <= GET_A;
            toCnt_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            toCnt_q <= toCnt_d;
            if (popEn) begin
              if (state_q == GET_B) begin
                aluB_q  <= bus.r_data;
                state_q <= GET_OP;
              end else begin
                aluOp_q <= bus.r_data[OP_W-1:0];
                state_q <= EXEC;
              end
            end
          end
        end
        EXEC: begin
          wData_q <= bus.alu_result;
          toCnt_q <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (pushEn) begin
            state_q     <= GET_A;
            frameDone_q <= 1'b1;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign bus.rd         = popEn;
  assign bus.wr         = pushEn;
  assign bus.w_data     = wData_q;
  assign bus.alu_a      = aluA_q;
  assign bus.alu_b      = aluB_q;
  assign bus.alu_op     = aluOp_q;
  assign bus.busy       = (state_q != GET_A);
  assign bus.frame_done = frameDone_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: RX/TX FIFOs and the ALU are modelled with queues and a function;
// table vectors, hand-written corner sequences and a randomized frame stream are scored.
module tb_uart_alu_ctrl;

  logic clk = 1'b0;
  logic reset;

  uart_alu_ctrl_if #(.DATA_W(8), .OP_W(6)) bus ();

  uart_alu_ctrl #(
    .DATA_W(8), .OP_W(6), .TIMEOUT_CYCLES(10), .TO_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] expResult;
    logic [5:0] expOp;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];
  logic [7:0] byteQ[$];
  logic [7:0] expQ[$];

  int checks = 0;
  int passes = 0;
  int cycleNo = 0;
  int rdPulses = 0;
  int wrPulses = 0;
  int doneSeen = 0;
  int timeoutSeen = 0;
  int overlapBad = 0;
  int firstRdCycle = -1;
  int firstWrCycle = -1;
  logic       sawRd;
  logic       sawWr;
  logic [7:0] sawWData;

  // Reference ALU: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, anything else passes A.
  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb bus.alu_result = aluRef(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic refreshRx();
    bus.rx_empty = (rxQ.size() == 0);
    bus.r_data   = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
  endtask

  task automatic pushRx(input logic [7:0] b);
    rxQ.push_back(b);
    refreshRx();
  endtask

  // One clock: capture strobes at the edge, update FIFO models, then sample registered outputs.
  task automatic step();
    @(posedge clk);
    sawRd    = bus.rd;
    sawWr    = bus.wr;
    sawWData = bus.w_data;
    #1;
    cycleNo++;
    if (sawRd) begin
      rdPulses++;
      if (firstRdCycle < 0) firstRdCycle = cycleNo;
      if (rxQ.size() > 0) void'(rxQ.pop_front());
    end
    if (sawWr) begin
      wrPulses++;
      if (firstWrCycle < 0) firstWrCycle = cycleNo;
      txQ.push_back(sawWData);
    end
    refreshRx();
    #1;
    if (bus.frame_done) doneSeen++;
    if (bus.timeout) timeoutSeen++;
    if (bus.frame_done && bus.timeout) overlapBad++;
  endtask

  task automatic waitDone(input string name);
    int startDone;
    int n;
    startDone = doneSeen;
    n = 0;
    while (doneSeen == startDone && n < 60) begin
      step();
      n++;
    end
    checkOutput({name, "_frame_done"}, 32'(doneSeen - startDone), 1);
  endtask

  function automatic logic [7:0] lastTx(input int back);
    if (txQ.size() > back) return txQ[txQ.size() - 1 - back];
    return 8'hxx;
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    int rd0;
    int wr0;
    rd0 = rdPulses;
    wr0 = wrPulses;
    pushRx(v.a);
    pushRx(v.b);
    pushRx(v.op);
    waitDone($sformatf("vec%0d", idx));
    checkOutput($sformatf("vec%0d_result", idx), lastTx(0), v.expResult);
    checkOutput($sformatf("vec%0d_alu_a", idx), bus.alu_a, v.a);
    checkOutput($sformatf("vec%0d_alu_b", idx), bus.alu_b, v.b);
    checkOutput($sformatf("vec%0d_alu_op", idx), bus.alu_op, v.expOp);
    checkOutput($sformatf("vec%0d_rd_count", idx), 32'(rdPulses - rd0), 3);
    checkOutput($sformatf("vec%0d_wr_count", idx), 32'(wrPulses - wr0), 1);
    checkOutput($sformatf("vec%0d_busy", idx), bus.busy, 0);
  endtask

  initial begin
    int rd0;
    int wr0;
    int to0;
    int done0;
    int k;
    int stallBad;
    int extraWr;
    int gap;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] bases[5];

    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20};
    vecs[1] = '{8'h0A, 8'h01, 8'h22, 8'h09, 6'h22};
    vecs[2] = '{8'hF0, 8'h0F, 8'h24, 8'h00, 6'h24};
    vecs[3] = '{8'hFF, 8'h01, 8'h20, 8'h00, 6'h20};
    vecs[4] = '{8'h12, 8'h34, 8'hE0, 8'h46, 6'h20};
    vecs[5] = '{8'hAA, 8'h55, 8'h26, 8'hFF, 6'h26};
    vecs[6] = '{8'hC0, 8'h0C, 8'h65, 8'hCC, 6'h25};
    vecs[7] = '{8'h7B, 8'h3C, 8'h7F, 8'h7B, 6'h3F};

    reset = 1'b1;
    bus.tx_full = 1'b0;
    refreshRx();
    repeat (3) step();

    checkOutput("reset_alu_a", bus.alu_a, 0);
    checkOutput("reset_alu_b", bus.alu_b, 0);
    checkOutput("reset_alu_op", bus.alu_op, 0);
    checkOutput("reset_w_data", bus.w_data, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_frame_done", bus.frame_done, 0);
    checkOutput("reset_timeout", bus.timeout, 0);
    pushRx(8'h99);
    #1;
    checkOutput("reset_rd_gated", bus.rd, 0);
    checkOutput("reset_wr_gated", bus.wr, 0);
    rxQ.delete();
    refreshRx();
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Back-to-back frames: first push exactly four cycles after the first pop.
    firstRdCycle = -1;
    firstWrCycle = -1;
    rd0 = rdPulses;
    wr0 = wrPulses;
    pushRx(8'h0A); pushRx(8'h01); pushRx(8'h22);
    pushRx(8'hF0); pushRx(8'h0F); pushRx(8'h24);
    waitDone("b2b_first");
    waitDone("b2b_second");
    checkOutput("b2b_latency", 32'(firstWrCycle - firstRdCycle), 4);
    checkOutput("b2b_result0", lastTx(1), 8'h09);
    checkOutput("b2b_result1", lastTx(0), 8'h00);
    checkOutput("b2b_rd_count", 32'(rdPulses - rd0), 6);
    checkOutput("b2b_wr_count", 32'(wrPulses - wr0), 2);

    // TX back-pressure held for 20 cycles in SEND with a second frame waiting in RX.
    bus.tx_full = 1'b1;
    rd0 = rdPulses;
    wr0 = wrPulses;
    pushRx(8'h40); pushRx(8'h02); pushRx(8'h22);
    pushRx(8'h3C); pushRx(8'h0F); pushRx(8'h25);
    repeat (4) step();
    stallBad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rd || bus.wr || bus.w_data !== 8'h3E || !bus.busy) stallBad++;
      step();
    end
    checkOutput("bp_stall_violations", stallBad, 0);
    checkOutput("bp_rd_count_stalled", 32'(rdPulses - rd0), 3);
    checkOutput("bp_wr_count_stalled", 32'(wrPulses - wr0), 0);
    bus.tx_full = 1'b0;
    #1;
    checkOutput("bp_wr_on_release", bus.wr, 1);
    checkOutput("bp_w_data", bus.w_data, 8'h3E);
    waitDone("bp_first");
    waitDone("bp_second");
    checkOutput("bp_result0", lastTx(1), 8'h3E);
    checkOutput("bp_result1", lastTx(0), 8'h3F);

    // Timeout: single byte then silence.
    wr0 = wrPulses;
    to0 = timeoutSeen;
    pushRx(8'h11);
    step();
    checkOutput("to_first_pop", sawRd, 1);
    k = 0;
    while (!bus.timeout && k < 30) begin
      step();
      k++;
    end
    checkOutput("to_cycles_after_pop", k, 10);
    checkOutput("to_busy_after", bus.busy, 0);
    checkOutput("to_no_wr", 32'(wrPulses - wr0), 0);
    step();
    checkOutput("to_single_pulse", bus.timeout, 0);
    checkOutput("to_pulse_count", 32'(timeoutSeen - to0), 1);
    pushRx(8'h02); pushRx(8'h02); pushRx(8'h20);
    waitDone("to_followup");
    checkOutput("to_followup_result", lastTx(0), 8'h04);

    // Pop arriving on the expiry cycle wins over the timeout.
    to0 = timeoutSeen;
    pushRx(8'h11);
    step();
    repeat (9) step();
    pushRx(8'h22);
    step();
    checkOutput("race_pop_taken", sawRd, 1);
    checkOutput("race_no_timeout", bus.timeout, 0);
    checkOutput("race_busy", bus.busy, 1);
    pushRx(8'h20);
    waitDone("race");
    checkOutput("race_result", lastTx(0), 8'h33);
    checkOutput("race_timeout_count", 32'(timeoutSeen - to0), 0);

    // Reset after the first byte of a frame; queued bytes survive and form a fresh frame.
    pushRx(8'h07);
    step();
    pushRx(8'h01); pushRx(8'h02); pushRx(8'h20);
    reset = 1'b1;
    #1;
    checkOutput("mrst_rd_gated", bus.rd, 0);
    checkOutput("mrst_wr_gated", bus.wr, 0);
    step();
    checkOutput("mrst_alu_a", bus.alu_a, 0);
    checkOutput("mrst_w_data", bus.w_data, 0);
    checkOutput("mrst_busy", bus.busy, 0);
    checkOutput("mrst_rx_kept", rxQ.size(), 3);
    reset = 1'b0;
    waitDone("mrst");
    checkOutput("mrst_result", lastTx(0), 8'h03);
    checkOutput("mrst_alu_a_new", bus.alu_a, 8'h01);

    // Randomized frame stream with RX gaps and random TX back-pressure.
    bases = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26};
    for (int f = 0; f < 40; f++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = bases[$urandom_range(0, 4)] | 8'($urandom_range(0, 3) << 6);
      byteQ.push_back(a);
      byteQ.push_back(b);
      byteQ.push_back(op);
      expQ.push_back(aluRef(a, b, op[5:0]));
    end
    done0 = doneSeen;
    to0 = timeoutSeen;
    extraWr = 0;
    gap = 0;
    for (int cyc = 0; cyc < 4000 && (expQ.size() > 0 || doneSeen - done0 < 40); cyc++) begin
      if (byteQ.size() > 0) begin
        if (gap == 0) begin
          pushRx(byteQ.pop_front());
          gap = $urandom_range(0, 4);
        end else begin
          gap--;
        end
      end
      bus.tx_full = ($urandom_range(0, 3) == 0);
      step();
      if (sawWr) begin
        if (expQ.size() > 0) checkOutput("rand_w_data", sawWData, expQ.pop_front());
        else extraWr++;
      end
    end
    bus.tx_full = 1'b0;
    checkOutput("rand_results_left", expQ.size(), 0);
    checkOutput("rand_extra_wr", extraWr, 0);
    checkOutput("rand_frame_done_count", 32'(doneSeen - done0), 40);
    checkOutput("rand_timeout_count", 32'(timeoutSeen - to0), 0);
    checkOutput("rand_rx_drained", rxQ.size(), 0);

    checkOutput("done_timeout_overlap", overlapBad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Frame sequencer between the UART RX/TX FIFOs and the combinational ALU.
- Pops a 3-byte command frame from the RX FIFO: operand A, then operand B, then opcode.
- Presents the frame to the ALU and captures the result one cycle later.
- Pushes the result byte into the TX FIFO; replaces the loopback test logic as the UART-side controller.

Parameters:
- DATA_W, 8, width of FIFO data, ALU operands and result.
- OP_W, 6, opcode width; the low OP_W bits of the opcode byte are used.
- TIMEOUT_CYCLES, 50000, idle cycles allowed between bytes of one frame; 0 disables the timeout.
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- r_data  in  DATA_W  RX FIFO head byte; valid while rx_empty=0
- rx_empty  in  1  RX FIFO empty flag
- rd  out  1  RX FIFO pop strobe
- w_data  out  DATA_W  byte to TX FIFO
- tx_full  in  1  TX FIFO full flag
- wr  out  1  TX FIFO push strobe
- alu_a  out  DATA_W  operand A register
- alu_b  out  DATA_W  operand B register
- alu_op  out  OP_W  opcode register
- alu_result  in  DATA_W  combinational ALU result
- busy  out  1  high whenever state != GET_A
- frame_done  out  1  one-cycle pulse when the result byte is pushed
- timeout  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset and clocking:
  - Single clock domain; reset is sampled on the rising edge of clk.
  - Reset state: state=GET_A; alu_a=alu_b=w_data=0; alu_op=0; timeout counter=0; frame_done=timeout=0; busy=0.
  - While reset=1, rd=0 and wr=0 (gated).
- FIFO handshake:
  - rd is combinational: rd = !reset && state∈{GET_A,GET_B,GET_OP} && !rx_empty.
  - On the same edge, r_data is latched and the state advances, so each pop takes exactly one byte. No double pop is possible because the state leaves the byte-accepting position on that edge.
  - wr is combinational: wr = !reset && state==SEND && !tx_full.
  - w_data is registered and stable during SEND.
- State machine:
  - GET_A: on pop, alu_a<=r_data, go to GET_B. No timeout counting in this state (counter held at 0).
  - GET_B: on pop, alu_b<=r_data, go to GET_OP.
  - GET_OP: on pop, alu_op<=r_data[OP_W-1:0], go to EXEC.
  - EXEC: exactly one cycle; w_data<=alu_result, go to SEND. The ALU sees stable registers for a full cycle.
  - SEND: stay while tx_full=1. On the wr edge, go to GET_A with frame_done=1 for the next cycle.
- Latency:
  - With an empty TX FIFO and back-to-back RX bytes: pops on cycles N, N+1, N+2; EXEC at N+3; wr at N+4.
  - Minimum 5 cycles per frame.
- Timeout:
  - In GET_B and GET_OP, the counter increments each cycle with no pop and clears on every pop.
  - When the counter reaches TIMEOUT_CYCLES-1 with no pop that cycle: go to GET_A, counter<=0, timeout pulses one cycle. Captured operands remain but are overwritten by the next frame.
  - Pop and timeout in the same cycle: the pop wins and no timeout is raised.
  - TIMEOUT_CYCLES=0: the counter never fires.
- Boundaries:
  - tx_full held high: the controller stalls in SEND indefinitely; no RX bytes are popped meanwhile (back-pressure reaches the RX FIFO).
  - Reset mid-frame: partial operands are discarded. Bytes still in the RX FIFO are not popped during reset and are consumed afterwards as a new frame starting at GET_A.
  - alu_op width truncation: opcode byte bits above OP_W are ignored.
- Outputs:
  - frame_done and timeout are registered and never both high in one cycle.

Test Plan:
- Single frame: push 0x05, 0x03, 0x20 (ADD) into RX; ALU model returns a+b -> exactly 3 rd pulses; alu_a=0x05, alu_b=0x03, alu_op=0x20; one wr with w_data=0x08; frame_done pulses once; busy low afterwards.
- Back-to-back frames: 6 bytes preloaded (0x0A,0x01,0x22 SUB; 0xF0,0x0F,0x24 AND) -> wr bytes 0x09 then 0x00; first wr exactly 4 cycles after the first rd; no lost or duplicated pops.
- TX back-pressure: tx_full=1 for 20 cycles on entering SEND -> wr=0 and rd=0 throughout; w_data stays stable; a single wr occurs the cycle after tx_full drops.
- Timeout with TIMEOUT_CYCLES=10: send only 0x11 then stall -> timeout pulses 10 cycles after the pop, state returns to GET_A, no wr. A following full frame 0x02,0x02,0x20 yields 0x04.
- Pop-vs-timeout race: second byte arrives exactly on the expiry cycle -> it is accepted, no timeout pulse, frame completes.
- Reset mid-frame: assert reset for 1 cycle after the first byte -> rd=wr=0 during reset; all outputs at reset values; the next 3 bytes form a fresh frame with the correct result.
